// File: rtl/ula_seq_if.sv
// Request/response bundle between the datapath controller and the ula_seq ALU.
// The controller (master) issues operations; the ALU (slave) returns the result, flags and handshake.
interface ula_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       ULAControl;
  logic [WIDTH-1:0] scrA;
  logic [WIDTH-1:0] scrB;
  logic [WIDTH-1:0] ULAResult;
  logic             Z;
  logic             C;
  logic             N;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, ULAControl, scrA, scrB,
    input  ULAResult, Z, C, N, V, busy, done
  );

  modport slave (
    input  start, ULAControl, scrA, scrB,
    output ULAResult, Z, C, N, V, busy, done
  );
endinterface

// File: rtl/ula_seq.sv
// Registered ALU: single-cycle add/sub/logic/compare, WIDTH-cycle shift-add multiply.
// Latency 1 (multiply WIDTH+1); start is ignored while busy, no other backpressure.
module ula_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  ula_seq_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a, b, b_eff;
  logic [2:0]         op;
  logic               is_sub;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic [2*WIDTH-1:0] acc_nxt;
  logic               fin_en, fin_c, fin_v;
  logic [WIDTH-1:0]   fin_res;

  assign a      = bus.scrA;
  assign b      = bus.scrB;
  assign op     = bus.ULAControl;
  assign is_sub = (op == 3'b001);
  assign b_eff  = is_sub ? ~b : b;
  // Subtract reuses the adder as A + ~B + 1, so carry-out means "no borrow".
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    fin_en   = 1'b0;
    fin_res  = alu_res;
    fin_c    = alu_c;
    fin_v    = alu_v;

    if (state_q == IDLE) begin
      if (bus.start) begin
        if ((op == 3'b111) && (MUL_EN != 0)) begin
          state_d  = MUL;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          fin_en = 1'b1;
        end
      end
    end else begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        fin_en  = 1'b1;
        fin_res = acc_nxt[WIDTH-1:0];
        fin_c   = |acc_nxt[2*WIDTH-1:WIDTH];
        fin_v   = 1'b0;
      end
    end

    result_d = fin_en ? fin_res : result_q;
    z_d      = fin_en ? ~|fin_res : z_q;
    n_d      = fin_en ? fin_res[WIDTH-1] : n_q;
    c_d      = fin_en ? fin_c : c_q;
    v_d      = fin_en ? fin_v : v_q;
    done_d   = fin_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign bus.ULAResult = result_q;
  assign bus.Z         = z_q;
  assign bus.C         = c_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;
  assign bus.busy      = (state_q == MUL);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: 8-bit with multiplier, 8-bit without, and a 16-bit instance.
module tb_ula_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ula_seq_if #(.WIDTH(8))  b8();
  ula_seq_if #(.WIDTH(8))  bn();
  ula_seq_if #(.WIDTH(16)) b16();

  ula_seq #(.WIDTH(8),  .MUL_EN(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  ula_seq #(.WIDTH(8),  .MUL_EN(0)) u8n (.clk(clk), .rst_n(rst_n), .bus(bn));
  ula_seq #(.WIDTH(16), .MUL_EN(1)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  // Issue one op on the 8-bit multiplier instance and wait (bounded) for done.
  // lat counts cycles from the start-sampling edge; done_nxt is done one cycle later.
  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [3:0] f, output int lat,
                        output int busy_cyc, output logic done_nxt);
    @(negedge clk);
    b8.start = 1'b1; b8.ULAControl = op; b8.scrA = a; b8.scrB = b;
    @(negedge clk);
    b8.start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!b8.done && lat < 40) begin
      if (b8.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    r = b8.ULAResult;
    f = {b8.Z, b8.C, b8.N, b8.V};
    @(negedge clk);
    done_nxt = b8.done;
  endtask

  task automatic test_reset();
    b8.start = 1'b0; b8.ULAControl = 3'b000; b8.scrA = '0; b8.scrB = '0;
    bn.start = 1'b0; bn.ULAControl = 3'b000; bn.scrA = '0; bn.scrB = '0;
    b16.start = 1'b0; b16.ULAControl = 3'b000; b16.scrA = '0; b16.scrB = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b8.ULAResult, b8.Z, b8.C, b8.N, b8.V, b8.busy, b8.done} !== 14'h0) begin
      n_fail++; $display("FAIL reset_w8 got %h required 0", {b8.ULAResult, b8.Z, b8.C, b8.N, b8.V, b8.busy, b8.done});
    end
    n_checks++;
    if ({b16.ULAResult, b16.Z, b16.C, b16.N, b16.V, b16.busy, b16.done} !== 22'h0) begin
      n_fail++; $display("FAIL reset_w16 got %h required 0", {b16.ULAResult, b16.Z, b16.C, b16.N, b16.V, b16.busy, b16.done});
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic dn;
    issue8(3'b000, 8'hFF, 8'h01, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h00, 4'b1100} || lat != 1 || dn !== 1'b0) begin
      n_fail++; $display("FAIL add_ff_01 got r=%h zcnv=%b lat=%0d done_nxt=%b required r=00 zcnv=1100 lat=1 done_nxt=0", r, f, lat, dn);
    end
    issue8(3'b000, 8'h7F, 8'h01, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h80, 4'b0011}) begin
      n_fail++; $display("FAIL add_7f_01 got r=%h zcnv=%b required r=80 zcnv=0011", r, f);
    end
    issue8(3'b001, 8'h80, 8'h01, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h7F, 4'b0101}) begin
      n_fail++; $display("FAIL sub_80_01 got r=%h zcnv=%b required r=7f zcnv=0101", r, f);
    end
    issue8(3'b001, 8'h01, 8'h02, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'hFF, 4'b0010}) begin
      n_fail++; $display("FAIL sub_01_02 got r=%h zcnv=%b required r=ff zcnv=0010", r, f);
    end
    issue8(3'b001, 8'h05, 8'h05, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h00, 4'b1100}) begin
      n_fail++; $display("FAIL sub_05_05 got r=%h zcnv=%b required r=00 zcnv=1100", r, f);
    end
  endtask

  task automatic test_logic_cmp();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic dn;
    issue8(3'b110, 8'hFF, 8'h01, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h01, 4'b0000}) begin
      n_fail++; $display("FAIL slt_ff_01 got r=%h zcnv=%b required r=01 zcnv=0000", r, f);
    end
    issue8(3'b101, 8'hFF, 8'h01, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h00, 4'b1000}) begin
      n_fail++; $display("FAIL sltu_ff_01 got r=%h zcnv=%b required r=00 zcnv=1000", r, f);
    end
    issue8(3'b100, 8'hA5, 8'hFF, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h5A, 4'b0000}) begin
      n_fail++; $display("FAIL xor_a5_ff got r=%h zcnv=%b required r=5a zcnv=0000", r, f);
    end
    issue8(3'b010, 8'hF0, 8'h3C, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h30, 4'b0000}) begin
      n_fail++; $display("FAIL and_f0_3c got r=%h zcnv=%b required r=30 zcnv=0000", r, f);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b8.start = 1'b1; b8.ULAControl = 3'b000; b8.scrA = 8'h03; b8.scrB = 8'h04;
    @(negedge clk);
    n_checks++;
    if (b8.done !== 1'b1 || b8.ULAResult !== 8'h07) begin
      n_fail++; $display("FAIL b2b_first got done=%b r=%h required done=1 r=07", b8.done, b8.ULAResult);
    end
    b8.ULAControl = 3'b011; b8.scrA = 8'hF0; b8.scrB = 8'h0F;
    @(negedge clk);
    b8.start = 1'b0;
    n_checks++;
    if (b8.done !== 1'b1 || b8.ULAResult !== 8'hFF || b8.N !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got done=%b r=%h n=%b required done=1 r=ff n=1", b8.done, b8.ULAResult, b8.N);
    end
    @(negedge clk);
    n_checks++;
    if (b8.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_drop got done=%b required 0", b8.done);
    end
  endtask

  task automatic test_mul_hold();
    int done_cnt = 0; int done_cyc = 0; int busy_cnt = 0; int changed = 0;
    @(negedge clk);
    b8.start = 1'b1; b8.ULAControl = 3'b111; b8.scrA = 8'd13; b8.scrB = 8'd11;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      b8.scrA = 8'hFF; b8.scrB = 8'hFF; b8.ULAControl = 3'b000;
      if (b8.busy) begin
        busy_cnt++;
        if (b8.ULAResult !== 8'hFF) changed++;
      end
      if (b8.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        b8.start = 1'b0;
        n_checks++;
        if (b8.ULAResult !== 8'h8F || {b8.Z, b8.C, b8.N, b8.V} !== 4'b0010) begin
          n_fail++; $display("FAIL mul_13_11 got r=%h zcnv=%b required r=8f zcnv=0010", b8.ULAResult, {b8.Z, b8.C, b8.N, b8.V});
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 9 || busy_cnt != 8) begin
      n_fail++; $display("FAIL mul_timing got dones=%0d done_cycle=%0d busy_cycles=%0d required 1/9/8", done_cnt, done_cyc, busy_cnt);
    end
    n_checks++;
    if (changed != 0) begin
      n_fail++; $display("FAIL mul_result_stable got %0d changed busy cycles required 0", changed);
    end
  endtask

  task automatic test_mul_reset();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic dn;
    int bad = 0;
    issue8(3'b111, 8'h10, 8'h10, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h00, 4'b1100} || lat != 9 || bc != 8) begin
      n_fail++; $display("FAIL mul_10_10 got r=%h zcnv=%b lat=%0d busy=%0d required r=00 zcnv=1100 lat=9 busy=8", r, f, lat, bc);
    end
    @(negedge clk);
    b8.start = 1'b1; b8.ULAControl = 3'b111; b8.scrA = 8'h10; b8.scrB = 8'h10;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b8.ULAResult, b8.Z, b8.C, b8.N, b8.V, b8.busy, b8.done} !== 14'h0) begin
      n_fail++; $display("FAIL mul_abort_reset got %h required 0", {b8.ULAResult, b8.Z, b8.C, b8.N, b8.V, b8.busy, b8.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b8.done || b8.busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mul_abort_quiet got %0d cycles with done/busy required 0", bad);
    end
    issue8(3'b000, 8'h02, 8'h03, r, f, lat, bc, dn);
    n_checks++;
    if ({r, f} !== {8'h05, 4'b0000} || lat != 1) begin
      n_fail++; $display("FAIL add_after_abort got r=%h zcnv=%b lat=%0d required r=05 zcnv=0000 lat=1", r, f, lat);
    end
  endtask

  task automatic test_mul_disabled();
    @(negedge clk);
    bn.start = 1'b1; bn.ULAControl = 3'b111; bn.scrA = 8'h05; bn.scrB = 8'h07;
    #1;
    n_checks++;
    if (bn.busy !== 1'b0 || bn.done !== 1'b0) begin
      n_fail++; $display("FAIL nomul_pre got busy=%b done=%b required 0 0", bn.busy, bn.done);
    end
    @(negedge clk);
    bn.start = 1'b0;
    n_checks++;
    if (bn.done !== 1'b1 || bn.busy !== 1'b0 || bn.ULAResult !== 8'h00 || bn.Z !== 1'b1 || bn.C !== 1'b0) begin
      n_fail++; $display("FAIL nomul_op7 got done=%b busy=%b r=%h z=%b c=%b required 1 0 00 1 0", bn.done, bn.busy, bn.ULAResult, bn.Z, bn.C);
    end
  endtask

  task automatic test_mul_w16();
    int lat = 1;
    @(negedge clk);
    b16.start = 1'b1; b16.ULAControl = 3'b111; b16.scrA = 16'h0100; b16.scrB = 16'h0100;
    @(negedge clk);
    b16.start = 1'b0;
    while (!b16.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (b16.ULAResult !== 16'h0000 || {b16.Z, b16.C, b16.N, b16.V} !== 4'b1100 || lat != 17) begin
      n_fail++; $display("FAIL mul16_100_100 got r=%h zcnv=%b lat=%0d required r=0000 zcnv=1100 lat=17", b16.ULAResult, {b16.Z, b16.C, b16.N, b16.V}, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_cmp();
    test_back_to_back();
    test_mul_hold();
    test_mul_reset();
    test_mul_disabled();
    test_mul_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
